// File: rtl/dict_update_ctrl.sv
// Sequencing controller for the FIFO dictionary: streams one cache line word by word,
// decides which words are pushed, and tracks the dictionary write pointer and valid mask.
module dict_update_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 16,
    parameter int DICT_ENTRIES   = 16
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_start,
    input  logic                                i_clear,
    input  logic                                i_word_valid,
    output logic                                o_word_ready,
    input  logic [DATA_WIDTH-1:0]               i_word,
    input  logic                                i_hit,
    output logic                                o_dict_wr,
    output logic [DATA_WIDTH-1:0]               o_dict_wdata,
    output logic [$clog2(DICT_ENTRIES)-1:0]     o_wr_ptr,
    output logic [DICT_ENTRIES-1:0]             o_valid_mask,
    output logic [$clog2(WORDS_PER_LINE):0]     o_push_count,
    output logic                                o_busy,
    output logic                                o_done
);

    localparam int PW = $clog2(DICT_ENTRIES);
    localparam int CW = $clog2(WORDS_PER_LINE);
    localparam int NW = CW + 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DICT_ENTRIES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_LINE - 1);
    localparam logic [NW-1:0] PC_MAX   = NW'(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q,  cnt_d;
    logic [PW-1:0]           ptr_q,  ptr_d;
    logic [DICT_ENTRIES-1:0] mask_q, mask_d;
    logic [NW-1:0]           pc_q,   pc_d;
    logic                    accept;
    logic                    push;
    logic                    last_word;

    assign accept    = (state_q == S_STREAM) && i_word_valid;
    assign push      = accept && !i_hit && (i_word != '0);
    assign last_word = accept && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        mask_d = mask_q;
        pc_d   = pc_q;
        if ((state_q == S_IDLE) && i_start) begin
            cnt_d = '0;
            pc_d  = '0;
        end
        if (accept) begin
            cnt_d = last_word ? '0 : cnt_q + 1'b1;
        end
        if (push) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            if (pc_q != PC_MAX) begin
                pc_d = pc_q + 1'b1;
            end
        end
        // Clear applies first so a same-cycle push leaves its own slot marked valid.
        if (i_clear) begin
            mask_d = '0;
        end
        if (push) begin
            mask_d = mask_d | (DICT_ENTRIES'(1) << ptr_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            mask_q  <= '0;
            pc_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            mask_q <= mask_d;
            pc_q   <= pc_d;
            case (state_q)
                S_IDLE:   if (i_start) state_q <= S_STREAM;
                S_STREAM: if (last_word) state_q <= S_DONE;
                S_DONE:   state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign o_word_ready = (state_q == S_STREAM);
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_dict_wr    = push;
    assign o_dict_wdata = i_word;
    assign o_wr_ptr     = ptr_q;
    assign o_valid_mask = mask_q;
    assign o_push_count = pc_q;

endmodule

// File: tb/tb_dict_update_ctrl.sv
// Directed bench for dict_update_ctrl: a per-cycle vector table for the filtering line
// plus hand-written sequences for wrap, bubbles, clear collision and mid-line reset.
module tb_dict_update_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, clr = 1'b0, vld = 1'b0, hit = 1'b0;
    logic [31:0] word = '0;
    logic        rdy, wr, busy, done;
    logic [31:0] wdata;
    logic [3:0]  ptr;
    logic [15:0] mask;
    logic [4:0]  pc;

    int checks = 0;
    int errors = 0;
    int npush  = 0;

    localparam bit B1 = 1'b1;
    localparam bit B0 = 1'b0;

    typedef struct {
        bit          s, c, v, h;
        logic [31:0] w;
        bit          e_wr, e_rdy, e_done;
        logic [3:0]  e_ptr;
        logic [15:0] e_mask;
        logic [4:0]  e_pc;
    } vec_t;

    vec_t tbl[18];

    dict_update_ctrl #(.DATA_WIDTH(32), .WORDS_PER_LINE(16), .DICT_ENTRIES(16)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_clear      (clr),
        .i_word_valid (vld),
        .o_word_ready (rdy),
        .i_word       (word),
        .i_hit        (hit),
        .o_dict_wr    (wr),
        .o_dict_wdata (wdata),
        .o_wr_ptr     (ptr),
        .o_valid_mask (mask),
        .o_push_count (pc),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input bit s, input bit c, input bit v, input bit h, input logic [31:0] w);
        start = s; clr = c; vld = v; hit = h; word = w;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit s, input bit c, input bit v, input bit h,
                                input logic [31:0] w, input bit e_wr, input bit e_rdy,
                                input bit e_done, input logic [3:0] p, input logic [15:0] m,
                                input logic [4:0] n);
        vec_t r;
        r.s = s; r.c = c; r.v = v; r.h = h; r.w = w;
        r.e_wr = e_wr; r.e_rdy = e_rdy; r.e_done = e_done;
        r.e_ptr = p; r.e_mask = m; r.e_pc = n;
        return r;
    endfunction

    // Full line of unique non-zero words starting from pointer 0.
    task automatic run_line(input logic [31:0] base);
        drv(B1, B0, B0, B0, 32'h0);
        #4;
        chk("idle_ready", 32'(rdy), 32'(1'b0));
        chk("idle_busy", 32'(busy), 32'(1'b0));
        tick;
        for (int i = 0; i < 16; i++) begin
            drv(B0, B0, B1, B0, base + 32'(i));
            #4;
            chk("ln_ready", 32'(rdy), 32'(1'b1));
            chk("ln_busy", 32'(busy), 32'(1'b1));
            chk("ln_wr", 32'(wr), 32'(1'b1));
            chk("ln_wdata", wdata, base + 32'(i));
            chk("ln_ptr_pre", 32'(ptr), 32'(i));
            chk("ln_done", 32'(done), 32'(1'b0));
            tick;
            chk("ln_pc", 32'(pc), 32'(i + 1));
            chk("ln_ptr", 32'(ptr), 32'((i + 1) % 16));
        end
        drv(B0, B0, B0, B0, 32'h0);
        #4;
        chk("ln_done_c17", 32'(done), 32'(1'b1));
        chk("ln_ready_c17", 32'(rdy), 32'(1'b0));
        chk("ln_mask", 32'(mask), 32'h0000_FFFF);
        chk("ln_pc_end", 32'(pc), 32'd16);
        tick;
        chk("ln_done_c18", 32'(done), 32'(1'b0));
        chk("ln_busy_c18", 32'(busy), 32'(1'b0));
    endtask

    initial begin
        #3;
        chk("rst_ready", 32'(rdy), 32'(1'b0));
        chk("rst_wr", 32'(wr), 32'(1'b0));
        chk("rst_ptr", 32'(ptr), 32'h0);
        chk("rst_mask", 32'(mask), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unique line, then a second one to bring the pointer round to 0 again.
        run_line(32'h1);
        run_line(32'h11);

        // Third line: first push lands in slot 0, mask stays full.
        drv(B1, B0, B0, B0, 32'h0);
        tick;
        drv(B0, B0, B1, B0, 32'hDEADBEEF);
        #4;
        chk("wrap_wr", 32'(wr), 32'(1'b1));
        chk("wrap_wdata", wdata, 32'hDEADBEEF);
        chk("wrap_ptr_pre", 32'(ptr), 32'h0);
        tick;
        chk("wrap_ptr", 32'(ptr), 32'h1);
        chk("wrap_mask", 32'(mask), 32'h0000_FFFF);
        chk("wrap_pc", 32'(pc), 32'h1);
        for (int i = 0; i < 15; i++) begin
            drv(B0, B0, B1, B0, 32'h0);
            #4;
            chk("zero_wr", 32'(wr), 32'(1'b0));
            tick;
        end
        drv(B0, B0, B0, B0, 32'h0);
        #4;
        chk("wrap_done", 32'(done), 32'(1'b1));
        chk("wrap_pc_end", 32'(pc), 32'h1);
        tick;

        // Mid-line reset after 7 accepted words.
        drv(B1, B0, B0, B0, 32'h0);
        tick;
        for (int i = 0; i < 7; i++) begin
            drv(B0, B0, B1, B0, 32'h50 + 32'(i));
            tick;
        end
        chk("mid_pc", 32'(pc), 32'h7);
        chk("mid_ptr", 32'(ptr), 32'h8);
        drv(B0, B0, B1, B0, 32'h99);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(rdy), 32'(1'b0));
        chk("mid_rst_wr", 32'(wr), 32'(1'b0));
        chk("mid_rst_ptr", 32'(ptr), 32'h0);
        chk("mid_rst_mask", 32'(mask), 32'h0);
        chk("mid_rst_pc", 32'(pc), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'(1'b0));
        chk("mid_rst_done", 32'(done), 32'(1'b0));
        drv(B0, B0, B0, B0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_nodone0", 32'(done), 32'(1'b0));
        tick;
        chk("mid_nodone1", 32'(done), 32'(1'b0));
        run_line(32'h100);

        // Zero/hit filtering line, with a clear issued together with start.
        tbl[0] = mk(B1, B1, B0, B0, 32'h0, B0, B0, B0, 4'd0, 16'h0000, 5'd0);
        for (int r = 1; r <= 8; r++)
            tbl[r] = mk(B0, B0, B1, B0, 32'h0, B0, B1, B0, 4'd0, 16'h0000, 5'd0);
        tbl[9]  = mk(B0, B0, B1, B0, 32'hA1, B1, B1, B0, 4'd1, 16'h0001, 5'd1);
        tbl[10] = mk(B0, B0, B1, B1, 32'hA2, B0, B1, B0, 4'd1, 16'h0001, 5'd1);
        tbl[11] = mk(B0, B0, B1, B0, 32'hA3, B1, B1, B0, 4'd2, 16'h0003, 5'd2);
        tbl[12] = mk(B0, B0, B1, B1, 32'hA4, B0, B1, B0, 4'd2, 16'h0003, 5'd2);
        tbl[13] = mk(B0, B0, B1, B0, 32'hA5, B1, B1, B0, 4'd3, 16'h0007, 5'd3);
        tbl[14] = mk(B0, B0, B1, B1, 32'hA6, B0, B1, B0, 4'd3, 16'h0007, 5'd3);
        tbl[15] = mk(B0, B0, B1, B0, 32'hA7, B1, B1, B0, 4'd4, 16'h000F, 5'd4);
        tbl[16] = mk(B0, B0, B1, B1, 32'hA8, B0, B1, B0, 4'd4, 16'h000F, 5'd4);
        tbl[17] = mk(B0, B0, B0, B0, 32'h0,  B0, B0, B1, 4'd4, 16'h000F, 5'd4);
        for (int r = 0; r < 18; r++) begin
            drv(tbl[r].s, tbl[r].c, tbl[r].v, tbl[r].h, tbl[r].w);
            #4;
            chk("tv_wr", 32'(wr), 32'(tbl[r].e_wr));
            chk("tv_ready", 32'(rdy), 32'(tbl[r].e_rdy));
            chk("tv_done", 32'(done), 32'(tbl[r].e_done));
            chk("tv_wdata", wdata, tbl[r].w);
            if (wr === 1'b1) npush++;
            tick;
            chk("tv_ptr", 32'(ptr), 32'(tbl[r].e_ptr));
            chk("tv_mask", 32'(mask), 32'(tbl[r].e_mask));
            chk("tv_pc", 32'(pc), 32'(tbl[r].e_pc));
        end
        chk("tv_npush", 32'(npush), 32'd4);

        // Bubbles on every other cycle: 16 words over cycles 2..32, DONE in cycle 33.
        drv(B1, B0, B0, B0, 32'h0);
        tick;
        for (int c = 1; c <= 32; c++) begin
            drv(B0, B0, (c % 2) == 0, B1, 32'hABC0 + 32'(c));
            #4;
            chk("bub_ready", 32'(rdy), 32'(1'b1));
            chk("bub_done", 32'(done), 32'(1'b0));
            chk("bub_wr", 32'(wr), 32'(1'b0));
            tick;
        end
        drv(B0, B0, B0, B0, 32'h0);
        #4;
        chk("bub_done_c33", 32'(done), 32'(1'b1));
        chk("bub_pc", 32'(pc), 32'h0);
        chk("bub_ptr", 32'(ptr), 32'h4);
        tick;
        chk("bub_idle", 32'(busy), 32'(1'b0));

        // Clear in the same cycle as a push at pointer 5.
        drv(B1, B0, B0, B0, 32'h0);
        tick;
        drv(B0, B0, B1, B0, 32'h1234);
        #4;
        chk("col_wr0", 32'(wr), 32'(1'b1));
        tick;
        chk("col_ptr5", 32'(ptr), 32'h5);
        chk("col_mask_pre", 32'(mask), 32'h001F);
        drv(B0, B1, B1, B0, 32'h5678);
        #4;
        chk("col_wr1", 32'(wr), 32'(1'b1));
        tick;
        chk("col_mask", 32'(mask), 32'h0020);
        chk("col_ptr", 32'(ptr), 32'h6);
        chk("col_pc", 32'(pc), 32'h2);
        for (int i = 0; i < 14; i++) begin
            drv(B0, B0, B1, B0, 32'h0);
            tick;
        end
        drv(B0, B0, B0, B0, 32'h0);
        #4;
        chk("col_done", 32'(done), 32'(1'b1));
        tick;
        drv(B0, B1, B0, B0, 32'h0);
        tick;
        chk("idle_clr_mask", 32'(mask), 32'h0);
        chk("idle_clr_ptr", 32'(ptr), 32'h6);
        drv(B0, B0, B0, B0, 32'h0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
